// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared FSM state encoding and default geometry for the
//                data-cache controller.
//  Revision    : 1.0  initial release
// ============================================================================
package dcache_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_OFF_W   = 2;
    localparam int DEF_IDX_W   = 5;
    localparam int DEF_MEM_LAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_tag_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_tag_array
//  Description : Direct-mapped tag/valid store, async clear, comb lookup,
//                single write port.
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_tag_array #(
    parameter int IDX_W = 5,
    parameter int TAG_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [TAG_W-1:0] tag_d [LINES];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];

endmodule : dcache_tag_array
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_controller
//  Description : Direct-mapped write-through, no-write-allocate D-cache FSM.
//                Define DCACHE_STATS_EN to add saturating hit/miss counters.
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OFF_W   = DEF_OFF_W,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic [IDX_W-1:0]  cache_idx,
    output logic [OFF_W-1:0]  cache_off,
    output logic              cache_we,
    output logic [DATA_W-1:0] cache_wdata,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = TAG_W + IDX_W;
    localparam int WAIT_W = $clog2(MEM_LAT + 1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [OFF_W-1:0]    word_q, word_d;
    logic [LINE_W-1:0]   line_q, line_d;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [OFF_W-1:0]    req_off;
    logic                lk_valid;
    logic [TAG_W-1:0]    lk_tag;
    logic                hit;
    logic                wait_last;
    logic                tag_we;

    assign req_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
    assign req_idx   = cpu_addr[OFF_W +: IDX_W];
    assign req_off   = cpu_addr[OFF_W-1:0];
    assign hit       = lk_valid && (lk_tag == req_tag);
    assign wait_last = (wait_q == WAIT_W'(MEM_LAT - 1));

    dcache_tag_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (req_idx),
        .rd_valid (lk_valid),
        .rd_tag   (lk_tag),
        .wr_en    (tag_we),
        .wr_idx   (line_q[IDX_W-1:0]),
        .wr_tag   (line_q[LINE_W-1:IDX_W])
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        word_d      = word_q;
        line_d      = line_q;
        stall       = 1'b0;
        tag_we      = 1'b0;
        cache_we    = 1'b0;
        cache_wdata = cpu_wdata;
        cache_idx   = req_idx;
        cache_off   = req_off;
        mem_addr    = cpu_addr;
        mem_we      = 1'b0;
        mem_wdata   = cpu_wdata;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_wr) begin
                    stall    = 1'b1;
                    cache_we = hit;
                    wait_d   = '0;
                    state_d  = ST_WRITE;
                end else if (cpu_rd && !hit) begin
                    stall   = 1'b1;
                    wait_d  = '0;
                    word_d  = '0;
                    line_d  = {req_tag, req_idx};
                    state_d = ST_REFILL;
                end
            end
            // The missing line address is latched so a dropped request still refills.
            ST_REFILL: begin
                stall       = 1'b1;
                cache_idx   = line_q[IDX_W-1:0];
                cache_off   = word_q;
                cache_wdata = mem_rdata;
                mem_addr    = {line_q, word_q};
                if (wait_last) begin
                    cache_we = 1'b1;
                    wait_d   = '0;
                    word_d   = word_q + OFF_W'(1);
                    if (word_q == '1) begin
                        tag_we  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WRITE: begin
                stall = 1'b1;
                if (wait_last) begin
                    mem_we  = 1'b1;
                    wait_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cpu_rdata = (cpu_rd && !stall) ? cache_rdata : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            word_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            word_q  <= word_d;
            line_q  <= line_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        retire_hit_q, retire_hit_d;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        hit_inc, miss_inc;

    // Stalled accesses retire in DONE; the hit/miss verdict is captured when they leave IDLE.
    always_comb begin
        retire_hit_d = retire_hit_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (cpu_wr)           retire_hit_d = hit;
            else if (cpu_rd && hit) hit_inc    = 1'b1;
            else if (cpu_rd)      retire_hit_d = 1'b0;
        end else if (state_q == ST_DONE) begin
            hit_inc  = retire_hit_q;
            miss_inc = !retire_hit_q;
        end
        hit_cnt_d  = (hit_inc  && hit_cnt_q  != 16'hFFFF) ? hit_cnt_q  + 16'd1 : hit_cnt_q;
        miss_cnt_d = (miss_inc && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            retire_hit_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            retire_hit_q <= retire_hit_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

`ifndef SYNTHESIS
    a_store_held: assert property (@(posedge CLK) disable iff (RST)
        (state_q == ST_WRITE) |-> cpu_wr);
`endif

endmodule : dcache_controller
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_controller
//  Description : Directed bench with a line-residency/memory reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_controller;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic [4:0]  cache_idx;
    logic [1:0]  cache_off;
    logic        cache_we;
    logic [31:0] cache_wdata, cache_rdata;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
    int          exp_hits = 0, exp_misses = 0;
`endif

    dcache_controller #(.MEM_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
        .cache_idx(cache_idx), .cache_off(cache_off), .cache_we(cache_we),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Environment: data memory and cache data array.
    logic [31:0] mem   [1024];
    logic [31:0] cdata [128];
    assign mem_rdata   = mem[mem_addr];
    assign cache_rdata = cdata[{cache_idx, cache_off}];
    always @(posedge CLK) begin
        if (mem_we)   mem[mem_addr] <= mem_wdata;
        if (cache_we) cdata[{cache_idx, cache_off}] <= cache_wdata;
    end

    // Reference model: architectural memory image plus which line each index holds.
    logic [31:0] ref_mem [1024];
    bit          res_valid [32];
    bit [2:0]    res_tag   [32];

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            res_valid[i] = 1'b0;
            res_tag[i]   = 3'd0;
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [9:0] a,
                          input logic [31:0] d, input string name,
                          output int stalls, output logic [31:0] rdata, output int we_pos);
        bit          is_store = wr;
        bit          exp_hit  = res_valid[a[6:2]] && (res_tag[a[6:2]] == a[9:7]);
        int          exp_stall = is_store ? LAT + 1 : (exp_hit ? 0 : 4 * LAT + 1);
        logic [31:0] exp_data = ref_mem[a];
        int          n_mwe = 0, n_cwe = 0, k = 0, cyc = 0;
        bit          timed_out = 0;
        stalls = 0;
        we_pos = -1;
        rdata  = '0;
        @(negedge CLK);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        forever begin
            #1;
            if (mem_we) begin
                n_mwe++;
                we_pos = cyc;
                chk({name, "_mem_addr"}, {22'd0, mem_addr}, {22'd0, a});
                chk({name, "_mem_wdata"}, mem_wdata, d);
            end
            if (cache_we) begin
                n_cwe++;
                if (is_store) begin
                    chk({name, "_cwe_data"}, cache_wdata, d);
                    chk({name, "_cwe_loc"}, {25'd0, cache_idx, cache_off}, {25'd0, a[6:0]});
                end else begin
                    chk({name, "_fill_addr"}, {22'd0, mem_addr}, {22'd0, a[9:2], 2'(k)});
                    chk({name, "_fill_loc"}, {25'd0, cache_idx, cache_off}, {25'd0, a[6:2], 2'(k)});
                    k++;
                end
            end
            if (!stall) break;
            stalls++;
            cyc++;
            if (cyc > 100) begin
                timed_out = 1;
                break;
            end
            @(negedge CLK);
        end
        chk({name, "_timeout"}, {31'd0, timed_out}, 32'd0);
        rdata = cpu_rdata;
        chk({name, "_stalls"}, stalls, exp_stall);
        chk({name, "_mem_we_cnt"}, n_mwe, is_store ? 1 : 0);
        chk({name, "_cache_we_cnt"}, n_cwe, is_store ? (exp_hit ? 1 : 0) : (exp_hit ? 0 : 4));
        if (!is_store) chk({name, "_rdata"}, rdata, exp_data);
        @(posedge CLK);
        if (is_store) ref_mem[a] = d;
        else if (!exp_hit) begin
            res_valid[a[6:2]] = 1'b1;
            res_tag[a[6:2]]   = a[9:7];
        end
`ifdef DCACHE_STATS_EN
        if (exp_hit) exp_hits++; else exp_misses++;
`endif
        if (timed_out) begin
            cpu_rd = 0; cpu_wr = 0;
        end
    endtask

    int          st, wp;
    logic [31:0] rd_v;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = {16'hC0DE, 6'd0, 10'(i)};
            ref_mem[i] = {16'hC0DE, 6'd0, 10'(i)};
        end
        for (int i = 0; i < 128; i++) cdata[i] = '0;
        model_reset();

        repeat (2) @(negedge CLK);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_cache_we", {31'd0, cache_we}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Cold miss, then a same-line hit.
        access(1, 0, 10'h044, 32'd0, "t1_ld044", st, rd_v, wp);
        chk("t1_stall_lit", st, 17);
        chk("t1_data_lit", rd_v, 32'hC0DE0044);
        access(1, 0, 10'h045, 32'd0, "t2_ld045", st, rd_v, wp);
        chk("t2_stall_lit", st, 0);
        chk("t2_data_lit", rd_v, 32'hC0DE0045);

        // Store hit, then reload.
        access(0, 1, 10'h045, 32'hDEADBEEF, "t3_st045", st, rd_v, wp);
        chk("t3_stall_lit", st, 5);
        chk("t3_wepos_lit", wp, 4);
        access(1, 0, 10'h045, 32'd0, "t3_ld045", st, rd_v, wp);
        chk("t3_reload_lit", rd_v, 32'hDEADBEEF);

        // Store miss does not allocate.
        access(0, 1, 10'h3F0, 32'h12345678, "t4_st3f0", st, rd_v, wp);
        access(1, 0, 10'h3F0, 32'd0, "t4_ld3f0", st, rd_v, wp);
        chk("t4_data_lit", rd_v, 32'h12345678);

        // Simultaneous rd+wr behaves as a store.
        access(1, 1, 10'h046, 32'h0AAA5555, "t7_rdwr046", st, rd_v, wp);
        access(1, 0, 10'h046, 32'd0, "t7_ld046", st, rd_v, wp);

        // Conflict eviction on index 17.
        access(1, 0, 10'h0C4, 32'd0, "t5_ld0c4", st, rd_v, wp);
        access(1, 0, 10'h0C5, 32'd0, "t5_ld0c5", st, rd_v, wp);
        access(1, 0, 10'h044, 32'd0, "t5_ld044", st, rd_v, wp);
        chk("t5_evict_lit", st, 17);

        // Reset while refilling word 2.
        @(negedge CLK);
        cpu_rd = 1; cpu_addr = 10'h100;
        repeat (9) @(negedge CLK);
        #1;
        chk("t6_pre_stall", {31'd0, stall}, 32'd1);
        RST = 1'b1; cpu_rd = 0;
        #1;
        chk("t6_stall_drop", {31'd0, stall}, 32'd0);
        chk("t6_cache_we", {31'd0, cache_we}, 32'd0);
        model_reset();
`ifdef DCACHE_STATS_EN
        exp_hits = 0; exp_misses = 0;
        chk("t6_hit_cnt0", {16'd0, hit_cnt}, 32'd0);
        chk("t6_miss_cnt0", {16'd0, miss_cnt}, 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        access(1, 0, 10'h100, 32'd0, "t6_ld100", st, rd_v, wp);
        chk("t6_remiss_lit", st, 17);
        access(1, 0, 10'h045, 32'd0, "t6_ld045", st, rd_v, wp);
        chk("t6_ld045_lit", rd_v, 32'hDEADBEEF);

`ifdef DCACHE_STATS_EN
        @(negedge CLK);
        cpu_rd = 0; cpu_wr = 0;
        #1;
        chk("stats_hits", {16'd0, hit_cnt}, exp_hits);
        chk("stats_misses", {16'd0, miss_cnt}, exp_misses);
`endif
        @(negedge CLK);
        cpu_rd = 0; cpu_wr = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dcache_controller
`default_nettype wire
